csr_file: RTL
=============

# csr_file

Machine/supervisor control-and-status register file and trap state holder for the RV32 core. Sits beside the fetch/decode stage: it answers CSR reads combinationally and commits CSR writes, trap entry, MRET and SRET on the clock edge. It also owns the privilege mode, the cycle/instret counters and timer-interrupt generation. All traps are taken to M-mode; there is no delegation.

## Interface
Parameters
- HARTID, 0, value returned by mhartid.
- MISA, 32'h4014_0100, value returned by misa (RV32, I, S, U).

Ports
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; when high, no architectural state except mcycle changes.
- csr_addr  in  12  CSR address for the read and the write.
- rs1Data  in  32  register-source write operand.
- csr_wdataSrc1  in  32  immediate write operand.
- csr_wdataSrc1En  in  1  selects the write operand: 1 = csr_wdataSrc1, 0 = rs1Data.
- csr_write / csr_set / csr_clear  in  1 each  CSRRW / CSRRS / CSRRC operation request.
- csr_rdata  out  32  current value of the CSR at csr_addr (combinational).
- csr_trap_take  in  1  trap entry request.
- csr_trap_pc  in  32  PC of the trapping instruction.
- csr_cause  in  32  cause value, stored unmodified into mcause.
- csr_mret / csr_sret  in  1 each  return requests.
- csr_trap_vector  out  32  trap target address.
- csr_ret_addr  out  32  return target: sepc when csr_sret=1, else mepc.
- csr_interrupt_timer  out  1  pending and enabled timer interrupt.
- current_priv  out  2  privilege mode: 00 = U, 01 = S, 11 = M.

## Operation
- Implemented CSRs:
  - mstatus 0x300: SIE[1], MIE[3], SPIE[5], MPIE[7], SPP[8], MPP[12:11]. All other bits read 0.
  - misa 0x301.
  - mie 0x304: only MTIE[7] is implemented.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] are forced to 0.
  - mcause 0x342.
  - mip 0x344: read-only; MTIP[7] only.
  - sstatus 0x100: view of SIE, SPIE and SPP within mstatus.
  - sepc 0x141: bits [1:0] are forced to 0.
  - mcycle/mcycleh 0xB00/0xB80.
  - minstret/minstreth 0xB02/0xB82.
  - mtimecmp/mtimecmph 0x7C0/0x7C1 (custom).
  - mhartid 0xF14.
- Unimplemented addresses read 0 and ignore writes. misa, mhartid and mip ignore writes.
- Write value, where src is the selected operand:
  - csr_write: src.
  - csr_set: old | src.
  - csr_clear: old & ~src.
- If more than one of csr_write/csr_set/csr_clear is high, the priority is write > set > clear.
- Trap entry (csr_trap_take, !stall):
  - mepc ← {csr_trap_pc[31:2], 2'b00}.
  - mcause ← csr_cause.
  - MPIE ← MIE; MIE ← 0; MPP ← priv; priv ← M.
- MRET: MIE ← MPIE, MPIE ← 1, priv ← MPP, MPP ← U.
- SRET: SIE ← SPIE, SPIE ← 1, priv ← {0, SPP}, SPP ← 0.
- Priority within one cycle: trap_take > mret > sret > CSR write. The lower-priority actions are dropped.
- csr_trap_vector:
  - When mtvec[1:0]=01 and csr_cause[31]=1: {mtvec[31:2],2'b00} + 4·csr_cause[3:0].
  - Otherwise: {mtvec[31:2],2'b00}.
- MTIP = ({mcycleh, mcycle} ≥ {mtimecmph, mtimecmp}), 64-bit unsigned comparison.
- csr_interrupt_timer = MTIP & MTIE & (priv≠M | MIE).
- mcycle increments every cycle, including stall cycles.
- minstret increments when !stall & !csr_trap_take.
- A CSR write to a counter half replaces that cycle's increment of the written half. The other half still carries normally.

## Timing
- Reads: csr_rdata, csr_trap_vector, csr_ret_addr, csr_interrupt_timer and current_priv are combinational from state and inputs, with 0-cycle latency.
- Writes, trap entry and returns commit at the posedge where the request is high and stall=0. The value is visible on reads from the next cycle.
- With stall=1, requests are ignored; the requester holds them until stall drops.
- Interrupt self-clearing: a timer trap taken from M-mode clears MIE, so csr_interrupt_timer drops one cycle after trap entry.
- Reset values:
  - priv = M.
  - mstatus, mie, mtvec, mscratch, mepc, sepc, mcause = 0.
  - mcycle, minstret = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - Resulting outputs: csr_interrupt_timer = 0, csr_trap_vector = 0, csr_ret_addr = 0, current_priv = 2'b11.
- rst has priority over every request in the same cycle.
- Counters wrap from all-ones to 0. The carry from mcycle into mcycleh is applied in the same cycle.

## Structure
- Package csr_pkg holds:
  - CSR address localparams.
  - Privilege encodings PRIV_U/S/M.
  - mstatus bit-position constants.
  - Cause constants.
- Sub-module csr_counter64 is a 64-bit counter with inc, write-low and write-high controls. It is instantiated for mcycle and minstret.

## Test plan
- Reset → current_priv = 11, csr_rdata@0x300 = 0, csr_interrupt_timer = 0; after 5 cycles, mcycle reads 5.
- CSRRW mtvec ← rs1Data 0x0000_0100, then csr_trap_take with pc 0x24, cause 0x0B → next cycle: mepc = 0x24, mcause = 0x0B, MIE = 0, MPP = 11, csr_trap_vector = 0x100.
- Set MPP = 00 and MPIE = 1, then MRET → priv = 00, MIE = 1, MPP = 00, csr_ret_addr = mepc.
- mtimecmp = 20, mtimecmph = 0, MTIE = 1, MIE = 1 → csr_interrupt_timer rises when mcycle ≥ 20; trap entry → it falls the next cycle.
- CSRRS then CSRRC mscratch with immediate 5'h0A over 0xF0 → 0xFA, then 0xF0. With stall held high, the write is not committed until stall drops.
- Simultaneous csr_trap_take and csr_write to mscratch → mscratch unchanged, trap committed. mcycle at 0xFFFF_FFFF → mcycleh increments.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the machine/supervisor CSR file: addresses,
// privilege encodings, mstatus layout and trap cause values.
package csr_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  localparam logic [11:0] CSR_SSTATUS   = 12'h100;
  localparam logic [11:0] CSR_SEPC      = 12'h141;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7C1;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int unsigned MST_SIE    = 1;
  localparam int unsigned MST_MIE    = 3;
  localparam int unsigned MST_SPIE   = 5;
  localparam int unsigned MST_MPIE   = 7;
  localparam int unsigned MST_SPP    = 8;
  localparam int unsigned MST_MPP_LO = 11;
  localparam int unsigned MIE_MTIE   = 7;
  localparam int unsigned MIP_MTIP   = 7;

  localparam logic [31:0] SSTATUS_MASK = 32'h0000_0122;

  localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'h0000_0002;
  localparam logic [31:0] CAUSE_ECALL_U      = 32'h0000_0008;
  localparam logic [31:0] CAUSE_ECALL_S      = 32'h0000_0009;
  localparam logic [31:0] CAUSE_ECALL_M      = 32'h0000_000B;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ  = 32'h8000_0007;

  typedef struct packed {
    logic [1:0] mpp;
    logic       spp;
    logic       mpie;
    logic       spie;
    logic       mie;
    logic       sie;
  } mstatus_t;

  function automatic logic [31:0] mstatus_pack(input mstatus_t s);
    logic [31:0] r;
    r = '0;
    r[MST_SIE]          = s.sie;
    r[MST_MIE]          = s.mie;
    r[MST_SPIE]         = s.spie;
    r[MST_MPIE]         = s.mpie;
    r[MST_SPP]          = s.spp;
    r[MST_MPP_LO +: 2]  = s.mpp;
    return r;
  endfunction

  function automatic mstatus_t mstatus_unpack(input logic [31:0] w);
    mstatus_t s;
    s.sie  = w[MST_SIE];
    s.mie  = w[MST_MIE];
    s.spie = w[MST_SPIE];
    s.mpie = w[MST_MPIE];
    s.spp  = w[MST_SPP];
    s.mpp  = w[MST_MPP_LO +: 2];
    return s;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half overwrites.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d, sum;

  // A half write overrides only that half; the untouched half keeps the
  // incremented value, so a low-half wrap still carries into the high half.
  always_comb begin
    sum   = cnt_q + {63'd0, inc_i};
    cnt_d = sum;
    if (wr_lo_i) cnt_d[31:0]  = wdata_i;
    if (wr_hi_i) cnt_d[63:32] = wdata_i;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// M/S-mode CSR file: combinational reads, clocked CSR writes, trap entry,
// MRET/SRET, privilege mode, cycle/instret counters and timer interrupt.
module csr_file #(
  parameter logic [31:0] HARTID = 32'd0,
  parameter logic [31:0] MISA   = 32'h4014_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1Data,
  input  logic [31:0] csr_wdataSrc1,
  input  logic        csr_wdataSrc1En,
  input  logic        csr_write,
  input  logic        csr_set,
  input  logic        csr_clear,
  output logic [31:0] csr_rdata,
  input  logic        csr_trap_take,
  input  logic [31:0] csr_trap_pc,
  input  logic [31:0] csr_cause,
  input  logic        csr_mret,
  input  logic        csr_sret,
  output logic [31:0] csr_trap_vector,
  output logic [31:0] csr_ret_addr,
  output logic        csr_interrupt_timer,
  output logic [1:0]  current_priv
);
  import csr_pkg::*;

  priv_e       priv_q, priv_d;
  mstatus_t    mst_q, mst_d;
  logic        mtie_q, mtie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] sepc_q, sepc_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mcycle, minstret;

  logic        trap_en, mret_en, sret_en, csr_we;
  logic        mtip;
  logic [31:0] src, wval, tvec_base;

  assign trap_en = csr_trap_take & ~stall;
  assign mret_en = csr_mret & ~stall & ~csr_trap_take;
  assign sret_en = csr_sret & ~stall & ~csr_trap_take & ~csr_mret;
  assign csr_we  = (csr_write | csr_set | csr_clear) & ~stall
                   & ~csr_trap_take & ~csr_mret & ~csr_sret;

  assign mtip = (mcycle >= mtimecmp_q);

  // Combinational read mux.
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = mstatus_pack(mst_q);
      CSR_SSTATUS:   csr_rdata = mstatus_pack(mst_q) & SSTATUS_MASK;
      CSR_MISA:      csr_rdata = MISA;
      CSR_MIE:       csr_rdata = {24'd0, mtie_q, 7'd0};
      CSR_MIP:       csr_rdata = {24'd0, mtip, 7'd0};
      CSR_MTVEC:     csr_rdata = mtvec_q;
      CSR_MSCRATCH:  csr_rdata = mscratch_q;
      CSR_MEPC:      csr_rdata = mepc_q;
      CSR_MCAUSE:    csr_rdata = mcause_q;
      CSR_SEPC:      csr_rdata = sepc_q;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MTIMECMP:  csr_rdata = mtimecmp_q[31:0];
      CSR_MTIMECMPH: csr_rdata = mtimecmp_q[63:32];
      CSR_MHARTID:   csr_rdata = HARTID;
      default:       csr_rdata = '0;
    endcase
  end

  // Write-value formation: write > set > clear, operand from imm or rs1.
  always_comb begin
    src = csr_wdataSrc1En ? csr_wdataSrc1 : rs1Data;
    if (csr_write)    wval = src;
    else if (csr_set) wval = csr_rdata | src;
    else              wval = csr_rdata & ~src;
  end

  // Next-state: trap > mret > sret > CSR write.
  always_comb begin
    priv_d     = priv_q;
    mst_d      = mst_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    sepc_d     = sepc_q;
    mtimecmp_d = mtimecmp_q;
    if (trap_en) begin
      mepc_d    = {csr_trap_pc[31:2], 2'b00};
      mcause_d  = csr_cause;
      mst_d.mpie = mst_q.mie;
      mst_d.mie  = 1'b0;
      mst_d.mpp  = priv_q;
      priv_d     = PRIV_M;
    end else if (mret_en) begin
      mst_d.mie  = mst_q.mpie;
      mst_d.mpie = 1'b1;
      mst_d.mpp  = PRIV_U;
      priv_d     = priv_e'(mst_q.mpp);
    end else if (sret_en) begin
      mst_d.sie  = mst_q.spie;
      mst_d.spie = 1'b1;
      mst_d.spp  = 1'b0;
      priv_d     = mst_q.spp ? PRIV_S : PRIV_U;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS:   mst_d = mstatus_unpack(wval);
        CSR_SSTATUS: begin
          mst_d.sie  = wval[MST_SIE];
          mst_d.spie = wval[MST_SPIE];
          mst_d.spp  = wval[MST_SPP];
        end
        CSR_MIE:       mtie_d = wval[MIE_MTIE];
        CSR_MTVEC:     mtvec_d = wval;
        CSR_MSCRATCH:  mscratch_d = wval;
        CSR_MEPC:      mepc_d = {wval[31:2], 2'b00};
        CSR_MCAUSE:    mcause_d = wval;
        CSR_SEPC:      sepc_d = {wval[31:2], 2'b00};
        CSR_MTIMECMP:  mtimecmp_d[31:0] = wval;
        CSR_MTIMECMPH: mtimecmp_d[63:32] = wval;
        default: ;
      endcase
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      priv_q     <= PRIV_M;
      mst_q      <= '0;
      mtie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      sepc_q     <= '0;
      mtimecmp_q <= '1;
    end else begin
      priv_q     <= priv_d;
      mst_q      <= mst_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      sepc_q     <= sepc_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata_i (wval),
    .cnt_o   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (~stall & ~csr_trap_take),
    .wr_lo_i (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata_i (wval),
    .cnt_o   (minstret)
  );

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign csr_trap_vector = (mtvec_q[1:0] == 2'b01 && csr_cause[31])
                           ? tvec_base + {26'd0, csr_cause[3:0], 2'b00}
                           : tvec_base;
  assign csr_ret_addr = csr_sret ? sepc_q : mepc_q;
  assign csr_interrupt_timer = mtip & mtie_q & ((priv_q != PRIV_M) | mst_q.mie);
  assign current_priv = priv_q;

endmodule
